// File: rtl/rocc_decoupler_pkg.sv
// Shared types and field widths for the RoCC command decoupler.
package rocc_decoupler_pkg;
    localparam int FUNCT_W = 7;
    localparam int RD_W    = 5;
    localparam int XLEN    = 64;
    // funct, rd, xd, xs1, xs2
    localparam int HDR_W   = FUNCT_W + RD_W + 3;

    typedef struct packed {
        logic [FUNCT_W-1:0] funct;
        logic [RD_W-1:0]    rd;
        logic               xd;
        logic               xs1;
        logic               xs2;
        logic [XLEN-1:0]    rs1;
        logic [XLEN-1:0]    rs2;
    } rocc_cmd_t;
endpackage

// File: rtl/rocc_cmd_fifo.sv
// Synchronous FIFO: registered pointers and occupancy, unreset storage.
module rocc_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    input  logic                       pop,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);
    localparam logic [OW-1:0] FULL = OW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign in_ready  = (occupancy != FULL);
    assign out_valid = (occupancy != '0);
    assign do_push   = push && in_ready;
    assign do_pop    = pop && out_valid;
    assign out_data  = mem[rd_ptr];

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      occupancy <= occupancy + 1'b1;
            else if (do_pop && !do_push) occupancy <= occupancy - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= in_data;
    end
endmodule

// File: rtl/rocc_cmd_decoupler.sv
// RoCC command decoupler: command FIFO, outstanding-response throttle, busy and error tracking.
module rocc_cmd_decoupler
    import rocc_decoupler_pkg::*;
#(
    parameter int xLen            = XLEN,
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       core_cmd_valid,
    output logic                       core_cmd_ready,
    input  logic [FUNCT_W-1:0]         core_cmd_funct,
    input  logic [RD_W-1:0]            core_cmd_rd,
    input  logic                       core_cmd_xd,
    input  logic                       core_cmd_xs1,
    input  logic                       core_cmd_xs2,
    input  logic [xLen-1:0]            core_cmd_rs1,
    input  logic [xLen-1:0]            core_cmd_rs2,
    output logic                       acc_cmd_valid,
    input  logic                       acc_cmd_ready,
    output logic [FUNCT_W-1:0]         acc_cmd_funct,
    output logic [RD_W-1:0]            acc_cmd_rd,
    output logic                       acc_cmd_xd,
    output logic                       acc_cmd_xs1,
    output logic                       acc_cmd_xs2,
    output logic [xLen-1:0]            acc_cmd_rs1,
    output logic [xLen-1:0]            acc_cmd_rs2,
    input  logic                       acc_resp_valid,
    output logic                       acc_resp_ready,
    input  logic [RD_W-1:0]            acc_resp_rd,
    input  logic [xLen-1:0]            acc_resp_data,
    output logic                       core_resp_valid,
    input  logic                       core_resp_ready,
    output logic [RD_W-1:0]            core_resp_rd,
    output logic [xLen-1:0]            core_resp_data,
    output logic                       rocc_busy,
    output logic                       err_unexpected_resp,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int W  = HDR_W + 2*xLen;
    localparam int CW = $clog2(MAX_OUTSTANDING+1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [W-1:0]  head;
    logic          fifo_ready, fifo_valid, push, pop, inc, dec, throttle;
    logic [CW-1:0] outstanding;

    // Ready is forced low while reset is held so nothing is taken during reset.
    assign core_cmd_ready = fifo_ready && !reset;
    assign push           = core_cmd_valid && core_cmd_ready;

    rocc_cmd_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .in_data   ({core_cmd_funct, core_cmd_rd, core_cmd_xd, core_cmd_xs1,
                     core_cmd_xs2, core_cmd_rs1, core_cmd_rs2}),
        .in_ready  (fifo_ready),
        .pop       (pop),
        .out_valid (fifo_valid),
        .out_data  (head),
        .occupancy (occupancy)
    );

    assign {acc_cmd_funct, acc_cmd_rd, acc_cmd_xd, acc_cmd_xs1,
            acc_cmd_xs2, acc_cmd_rs1, acc_cmd_rs2} = head;

    assign throttle      = acc_cmd_xd && (outstanding == MAX_CNT);
    assign acc_cmd_valid = fifo_valid && !throttle;
    assign pop           = acc_cmd_valid && acc_cmd_ready;

    assign core_resp_valid = acc_resp_valid;
    assign acc_resp_ready  = core_resp_ready;
    assign core_resp_rd    = acc_resp_rd;
    assign core_resp_data  = acc_resp_data;

    assign inc = pop && acc_cmd_xd;
    assign dec = core_resp_valid && core_resp_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outstanding         <= '0;
            err_unexpected_resp <= 1'b0;
        end else if (inc && !dec) begin
            outstanding <= outstanding + 1'b1;
        end else if (dec && !inc) begin
            if (outstanding == '0) err_unexpected_resp <= 1'b1;
            else                   outstanding <= outstanding - 1'b1;
        end
    end

    assign rocc_busy = (occupancy != '0) || (outstanding != '0);
endmodule
